// File: rtl/display_pkg.sv
// Shared types, segment patterns and helpers for the BCD display driver.
// Segment patterns are active-low; bit 7 is the decimal point, kept off.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Largest value representable in 'digits' decimal digits.
  function automatic longint unsigned max_value(input int digits);
    longint unsigned v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_display_driver_if.sv
// Request/result bundle between a counter block and the BCD display driver.
// The master issues load requests; the slave (the driver) returns digits and segments.
interface bcd_display_driver_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) ();
    logic [WIDTH-1:0]    bin;
    logic                load;
    logic                blank_zeros;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [4*DIGITS-1:0] bcd;
    logic [8*DIGITS-1:0] hex;

    modport master (
        output bin, load, blank_zeros,
        input  busy, done, overflow, bcd, hex
    );

    modport slave (
        input  bin, load, blank_zeros,
        output busy, done, overflow, bcd, hex
    );
endinterface

// File: rtl/seg7_encode.sv
// Combinational digit to active-low 7-segment encoder with a blanking override.
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [7:0] seg
);
    // NOTE: seg gets a value on every path before any branch, so no latch is inferred.
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end
endmodule

// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter driving DIGITS 7-segment displays.
// One bit is converted per clock; results are latched and announced with a done pulse.
module bcd_display_driver
    import display_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic           clk,
    input  logic           clrn,
    bcd_display_driver_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;
    localparam longint unsigned MAX_VAL = max_value(DIGITS);

    localparam logic [1:0] IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] SHIFT = 2'(ST_SHIFT);
    localparam logic [1:0] LATCH = 2'(ST_LATCH);

    logic [1:0]          state;
    logic [WIDTH-1:0]    sr;
    logic [SW-1:0]       scratch;
    logic [SW-1:0]       adj;
    logic [CW-1:0]       count;
    logic                ovf_pending;
    logic                done_r;
    logic                ovf_r;
    logic [SW-1:0]       bcd_r;
    logic [8*DIGITS-1:0] hex_r;
    logic [8*DIGITS-1:0] seg_w;
    logic [DIGITS-1:0]   lead;
    logic                all_zero;

    // Add-3 correction so each digit carries correctly on the following shift.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i+:4] >= 4'd5) adj[4*i+:4] = scratch[4*i+:4] + 4'd3;
        end
    end

    // lead[i] marks digit i as a leading zero; digit 0 always stays visible.
    always_comb begin
        lead     = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero && (scratch[4*i+:4] == 4'd0);
            lead[i]  = all_zero;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_encode u_seg (
            .digit (scratch[4*g+:4]),
            .blank (bus.blank_zeros & lead[g]),
            .seg   (seg_w[8*g+:8])
        );
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            sr          <= '0;
            scratch     <= '0;
            count       <= '0;
            ovf_pending <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
            bcd_r       <= '0;
            hex_r       <= {DIGITS{SEG_BLANK}};
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        sr          <= bus.bin;
                        scratch     <= '0;
                        count       <= CW'(WIDTH);
                        ovf_pending <= (64'(bus.bin) > MAX_VAL);
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, sr} <= {adj[SW-2:0], sr, 1'b0};
                    count         <= count - CW'(1);
                    if (count == CW'(1)) state <= LATCH;
                end
                LATCH: begin
                    ovf_r  <= ovf_pending;
                    bcd_r  <= ovf_pending ? '0 : scratch;
                    hex_r  <= ovf_pending ? {DIGITS{SEG_DASH}} : seg_w;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_r;
    assign bus.overflow = ovf_r;
    assign bus.bcd      = bcd_r;
    assign bus.hex      = hex_r;
endmodule
